alu_issue_stage: RTL

//  Execute-stage wrapper that sits directly upstream of the integer ALU and consumes its result.
//  - Accepts decoded integer ops from issue with a valid/ready handshake.
//  - Maps funct3/funct7 to the 4-bit ALU opcode and selects operands.
//  - Holds them in a one-entry operand register that drives the ALU, then captures the ALU result.
//  - Buffers results in a small FIFO towards writeback.

---
 rtl/alu_issue_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Execute-stage wrapper in front of the integer ALU: decodes funct3/funct7 into an ALU
// opcode, holds operands in a one-entry register that drives the ALU, and queues results.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_b5,
  input  logic             in_is_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rd,
  input  logic [TAG_W-1:0] in_tag,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BAD = 4'b1111;

  // Operand register (drives the ALU directly)
  logic             a_valid;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [4:0]       rd_q;
  logic [TAG_W-1:0] tag_q;
  logic             ill_q;

  // Result FIFO
  logic [31:0]      res_mem [DEPTH];
  logic [4:0]       rd_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [3:0] dec_op;
  logic       dec_ill;
  logic       fifo_full;
  logic       move;
  logic       push;
  logic       pop;
  logic       accept;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (in_funct3)
      3'b000:  dec_op = (in_funct7_b5 && !in_is_imm) ? OP_SUB : OP_ADD;
      3'b001:  dec_op = OP_SLL;
      3'b100:  dec_op = OP_XOR;
      3'b101:  dec_op = in_funct7_b5 ? OP_SRA : OP_SRL;
      3'b110:  dec_op = OP_OR;
      3'b111:  dec_op = OP_AND;
      default: begin
        // funct3 010/011 have no ALU opcode; flag them so writeback can trap
        dec_op  = OP_BAD;
        dec_ill = 1'b1;
      end
    endcase
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, while in_ready depends on out_ready combinationally.
  // flush blocks accept, push and pop for the cycle it is high.
  assign fifo_full = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign move      = a_valid && (!fifo_full || (out_valid && out_ready));
  assign in_ready  = !flush && (!a_valid || move);
  assign accept    = in_valid && in_ready;
  assign push      = move && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid <= 1'b1;
      op_q    <= dec_op;
      a_q     <= in_rs1;
      b_q     <= in_is_imm ? in_imm : in_rs2;
      rd_q    <= in_rd;
      tag_q   <= in_tag;
      ill_q   <= dec_ill;
    end else if (move) begin
      a_valid <= 1'b0;
    end
  end

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
        rd_mem[i]  <= '0;
        tag_mem[i] <= '0;
        ill_mem[i] <= 1'b0;
      end
    end else if (push) begin
      res_mem[wr_ptr] <= alu_y;
      rd_mem[wr_ptr]  <= rd_q;
      tag_mem[wr_ptr] <= tag_q;
      ill_mem[wr_ptr] <= ill_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      // A simultaneous push and pop is legal even when full: the head leaves as the tail fills
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_result  = res_mem[rd_ptr];
  assign out_rd      = rd_mem[rd_ptr];
  assign out_tag     = tag_mem[rd_ptr];
  assign out_illegal = ill_mem[rd_ptr];

endmodule
